// File: rtl/btb_pkg.sv
// rtl/btb_pkg.sv - shared sizing helpers and sweep state type for the BTB valid/PLRU array
package btb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } sweep_state_e;

    function automatic int num_sets(input int s_index);
        return 1 << s_index;
    endfunction

    function automatic int ways_w(input int ways);
        return $clog2(ways);
    endfunction

    function automatic int plru_w(input int ways);
        return ways - 1;
    endfunction

endpackage

// File: rtl/btb_plru_tree.sv
// rtl/btb_plru_tree.sv - combinational tree pseudo-LRU touch update and victim select
module btb_plru_tree
    import btb_pkg::*;
#(
    parameter  int WAYS   = 4,
    localparam int WAYS_W = ways_w(WAYS),
    localparam int PLRU_W = plru_w(WAYS)
) (
    input  logic [PLRU_W-1:0] plru,
    input  logic [WAYS_W-1:0] touch_way,
    input  logic [WAYS-1:0]   valid,
    output logic [PLRU_W-1:0] next_plru,
    output logic [WAYS_W-1:0] victim
);

    // Heap-ordered nodes: node n has lower child 2n+1 and upper child 2n+2.
    // A node bit of 0 sends the victim walk into the lower half.
    always_comb begin : touch_walk
        logic [WAYS_W-1:0] way_bits;
        logic [PLRU_W-1:0] node_mask;
        int                node;
        next_plru = plru;
        way_bits  = touch_way;
        node_mask = '0;
        node      = 0;
        for (int lvl = 0; lvl < WAYS_W; lvl++) begin
            node_mask = PLRU_W'(1) << node;
            if (way_bits[WAYS_W-1]) begin
                next_plru = next_plru & ~node_mask;
            end else begin
                next_plru = next_plru | node_mask;
            end
            node     = 2 * node + 1 + int'(way_bits[WAYS_W-1]);
            way_bits = way_bits << 1;
        end
    end

    always_comb begin : victim_walk
        logic [WAYS_W-1:0] tree_way;
        logic [WAYS_W-1:0] inv_way;
        logic [WAYS-1:0]   vbits;
        logic              sel;
        logic              found;
        int                node;
        tree_way = '0;
        sel      = 1'b0;
        node     = 0;
        for (int lvl = 0; lvl < WAYS_W; lvl++) begin
            sel      = |(plru & (PLRU_W'(1) << node));
            tree_way = (tree_way << 1) | WAYS_W'(sel);
            node     = 2 * node + 1 + int'(sel);
        end
        // An empty way always beats the tree choice; lowest index wins.
        inv_way = '0;
        found   = 1'b0;
        vbits   = valid;
        for (int i = 0; i < WAYS; i++) begin
            if (!vbits[0] && !found) begin
                inv_way = WAYS_W'(i);
                found   = 1'b1;
            end
            vbits = vbits >> 1;
        end
        victim = found ? inv_way : tree_way;
    end

endmodule

// File: rtl/btb_valid_plru_array.sv
// rtl/btb_valid_plru_array.sv - per-set valid bits and tree PLRU with sweep clear and write-first read
module btb_valid_plru_array
    import btb_pkg::*;
#(
    parameter  int S_INDEX  = 8,
    parameter  int WAYS     = 4,
    localparam int NUM_SETS = num_sets(S_INDEX),
    localparam int WAYS_W   = ways_w(WAYS),
    localparam int PLRU_W   = plru_w(WAYS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush_req,
    output logic               busy,
    input  logic               rd_en,
    input  logic [S_INDEX-1:0] raddr,
    output logic [WAYS-1:0]    rd_valid,
    output logic [WAYS_W-1:0]  rd_victim,
    input  logic               upd_en,
    input  logic [S_INDEX-1:0] upd_addr,
    input  logic [WAYS_W-1:0]  upd_way,
    input  logic               upd_set_valid,
    input  logic               upd_touch
);

    localparam logic [S_INDEX-1:0] LAST_IDX = S_INDEX'(NUM_SETS - 1);

    sweep_state_e       state;
    logic [S_INDEX-1:0] sweep_idx;

    logic [WAYS-1:0]   valid_mem [NUM_SETS];
    logic [PLRU_W-1:0] plru_mem  [NUM_SETS];

    logic [PLRU_W-1:0] upd_next_plru;
    logic [WAYS_W-1:0] upd_victim_unused;
    logic [WAYS-1:0]   rd_mux_valid;
    logic [PLRU_W-1:0] rd_mux_plru;
    logic [PLRU_W-1:0] rd_next_unused;
    logic [WAYS_W-1:0] rd_mux_victim;
    logic              bypass;

    assign busy = (state == SWEEP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SWEEP;
            sweep_idx <= '0;
        end else if (flush_req) begin
            state     <= SWEEP;
            sweep_idx <= '0;
        end else if (state == SWEEP) begin
            if (sweep_idx == LAST_IDX) begin
                state <= IDLE;
            end
            sweep_idx <= sweep_idx + S_INDEX'(1);
        end
    end

    // Storage carries no reset; the sweep is the only thing that clears it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == SWEEP) begin
                valid_mem[sweep_idx] <= '0;
                plru_mem[sweep_idx]  <= '0;
            end else if (upd_en) begin
                valid_mem[upd_addr][upd_way] <= upd_set_valid;
                if (upd_touch) begin
                    plru_mem[upd_addr] <= upd_next_plru;
                end
            end
        end
    end

    btb_plru_tree #(.WAYS(WAYS)) u_upd_tree (
        .plru      (plru_mem[upd_addr]),
        .touch_way (upd_way),
        .valid     (valid_mem[upd_addr]),
        .next_plru (upd_next_plru),
        .victim    (upd_victim_unused)
    );

    assign bypass = upd_en && (state == IDLE) && (upd_addr == raddr);

    // Same-set update this cycle is visible to the read.
    always_comb begin
        rd_mux_valid = valid_mem[raddr];
        rd_mux_plru  = plru_mem[raddr];
        if (bypass) begin
            rd_mux_valid[upd_way] = upd_set_valid;
            if (upd_touch) begin
                rd_mux_plru = upd_next_plru;
            end
        end
    end

    btb_plru_tree #(.WAYS(WAYS)) u_rd_tree (
        .plru      (rd_mux_plru),
        .touch_way ('0),
        .valid     (rd_mux_valid),
        .next_plru (rd_next_unused),
        .victim    (rd_mux_victim)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid  <= '0;
            rd_victim <= '0;
        end else if (rd_en) begin
            if (state == SWEEP) begin
                rd_valid  <= '0;
                rd_victim <= '0;
            end else begin
                rd_valid  <= rd_mux_valid;
                rd_victim <= rd_mux_victim;
            end
        end
    end

endmodule
